// File: rtl/enemy_chase.sv
// Enemy sprite controller: waits at the spawn point, then chases the chef one
// axis per frame, freezes while peppered, and latches once the chef is caught.
module enemy_chase #(
  parameter logic [9:0] START_X      = 10'd320,
  parameter logic [9:0] START_Y      = 10'd96,
  parameter logic [9:0] STEP         = 10'd1,
  parameter logic [9:0] MIN_X        = 10'd16,
  parameter logic [9:0] MAX_X        = 10'd623,
  parameter logic [9:0] MIN_Y        = 10'd16,
  parameter logic [9:0] MAX_Y        = 10'd463,
  parameter logic [9:0] SPAWN_FRAMES = 10'd60,
  parameter logic [9:0] CATCH_R      = 10'd8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       hit,
  input  logic [9:0] ChefX,
  input  logic [9:0] ChefY,
  output logic [9:0] EnemyX,
  output logic [9:0] EnemyY,
  output logic [1:0] enemy_dir,
  output logic       stunned,
  output logic       chef_caught
);

  typedef enum logic [1:0] {SPAWN, CHASE, STUNNED, CAUGHT} state_t;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic       stunned_q, caught_q;

  logic [9:0] dx, dy, step_x, step_y, tgt_x, tgt_y, nx, ny;

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Candidate moves: step is capped by the remaining distance so we never overshoot.
  always_comb begin
    dx     = absdiff(ChefX, x_q);
    dy     = absdiff(ChefY, y_q);
    step_x = min10(STEP, dx);
    step_y = min10(STEP, dy);
    tgt_x  = (ChefX > x_q) ? (x_q + step_x) : (x_q - step_x);
    tgt_y  = (ChefY > y_q) ? (y_q + step_y) : (y_q - step_y);
    nx     = clamp10(tgt_x, MIN_X, MAX_X);
    ny     = clamp10(tgt_y, MIN_Y, MAX_Y);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    unique case (state_q)
      SPAWN: begin
        x_d = START_X;
        y_d = START_Y;
        if (cnt_q == SPAWN_FRAMES - 10'd1) begin
          state_d = CHASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      CHASE: begin
        // Stun outranks catch; catch is judged on the pre-move position.
        if (hit) begin
          state_d = STUNNED;
        end else if (dx <= CATCH_R && dy <= CATCH_R) begin
          state_d = CAUGHT;
        end else if (dx >= dy && dx != '0) begin
          x_d = nx;
          if (nx != x_q) dir_d = (ChefX > x_q) ? DIR_RIGHT : DIR_LEFT;
        end else if (dy != '0) begin
          y_d = ny;
          if (ny != y_q) dir_d = (ChefY > y_q) ? DIR_DOWN : DIR_UP;
        end
      end
      STUNNED: begin
        if (!hit) state_d = CHASE;
      end
      CAUGHT: begin
        state_d = CAUGHT;
      end
      default: state_d = SPAWN;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= SPAWN;
      cnt_q     <= '0;
      x_q       <= START_X;
      y_q       <= START_Y;
      dir_q     <= DIR_RIGHT;
      stunned_q <= 1'b0;
      caught_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      // Flags follow the next state so they line up with the state register.
      stunned_q <= (state_d == STUNNED);
      caught_q  <= (state_d == CAUGHT);
    end
  end

  assign EnemyX      = x_q;
  assign EnemyY      = y_q;
  assign enemy_dir   = dir_q;
  assign stunned     = stunned_q;
  assign chef_caught = caught_q;

endmodule

// File: tb/tb_enemy_chase.sv
// Directed bench for enemy_chase: default instance plus a STEP=5, zero-radius
// instance used to show the enemy stops exactly on the chef coordinate.
module tb_enemy_chase;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1, hit = 1'b0;
  logic [9:0] ChefX = 10'd400, ChefY = 10'd96;
  logic [9:0] EnemyX, EnemyY;
  logic [1:0] enemy_dir;
  logic       stunned, chef_caught;

  logic       rst2 = 1'b1, hit2 = 1'b0;
  logic [9:0] chef2_x = 10'd320, chef2_y = 10'd300;
  logic [9:0] ex2, ey2;
  logic [1:0] dir2;
  logic       stn2, cgt2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit    sel;
    int    x, y, dir, stn, cgt;
    string tag;
  } exp_t;
  exp_t sb[$];

  always #5 frame_clk = ~frame_clk;

  enemy_chase dut (
    .frame_clk(frame_clk), .Reset(Reset), .hit(hit), .ChefX(ChefX), .ChefY(ChefY),
    .EnemyX(EnemyX), .EnemyY(EnemyY), .enemy_dir(enemy_dir),
    .stunned(stunned), .chef_caught(chef_caught)
  );

  enemy_chase #(.STEP(10'd5), .CATCH_R(10'd0)) dut5 (
    .frame_clk(frame_clk), .Reset(rst2), .hit(hit2), .ChefX(chef2_x), .ChefY(chef2_y),
    .EnemyX(ex2), .EnemyY(ey2), .enemy_dir(dir2),
    .stunned(stn2), .chef_caught(cgt2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push the outputs expected after the coming edge, then pop and compare after it.
  task automatic tick(input string tag, input int x, input int y, input int dir,
                      input int stn, input int cgt, input bit sel);
    exp_t e;
    e.sel = sel; e.x = x; e.y = y; e.dir = dir; e.stn = stn; e.cgt = cgt; e.tag = tag;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      chk({e.tag, ".x"},   int'(EnemyX),      e.x);
      chk({e.tag, ".y"},   int'(EnemyY),      e.y);
      chk({e.tag, ".dir"}, int'(enemy_dir),   e.dir);
      chk({e.tag, ".stn"}, int'(stunned),     e.stn);
      chk({e.tag, ".cgt"}, int'(chef_caught), e.cgt);
    end else begin
      chk({e.tag, ".x"},   int'(ex2),  e.x);
      chk({e.tag, ".y"},   int'(ey2),  e.y);
      chk({e.tag, ".dir"}, int'(dir2), e.dir);
      chk({e.tag, ".stn"}, int'(stn2), e.stn);
      chk({e.tag, ".cgt"}, int'(cgt2), e.cgt);
    end
  endtask

  initial begin
    // V1: reset then 60 held frames, then rightward chase
    Reset = 1'b1; ChefX = 10'd400; ChefY = 10'd96;
    tick("v1_reset", 320, 96, 0, 0, 0, 1'b0);
    Reset = 1'b0;
    for (int k = 1; k <= 60; k++) tick($sformatf("v1_spawn%0d", k), 320, 96, 0, 0, 0, 1'b0);
    for (int k = 1; k <= 20; k++) tick($sformatf("v1_chase%0d", k), 320 + k, 96, 0, 0, 0, 1'b0);

    // V3: 100 stunned frames, release, resume one frame later
    hit = 1'b1;
    for (int k = 1; k <= 100; k++) tick($sformatf("v3_stun%0d", k), 340, 96, 0, 1, 0, 1'b0);
    hit = 1'b0;
    tick("v3_release", 340, 96, 0, 0, 0, 1'b0);
    tick("v3_resume", 341, 96, 0, 0, 0, 1'b0);

    // V5: drive left into MIN_X and hold there
    ChefX = 10'd0;
    for (int k = 1; k <= 325; k++) tick($sformatf("v5_left%0d", k), 341 - k, 96, 1, 0, 0, 1'b0);
    for (int k = 1; k <= 5; k++) tick($sformatf("v5_clamp%0d", k), 16, 96, 1, 0, 0, 1'b0);

    // Upward move
    ChefX = 10'd16; ChefY = 10'd40;
    for (int k = 1; k <= 3; k++) tick($sformatf("up%0d", k), 16, 96 - k, 2, 0, 0, 1'b0);

    // V4: stun beats catch, then catch latches and ignores later hits
    ChefX = 10'd20; ChefY = 10'd90; hit = 1'b1;
    tick("v4_stun_over_catch", 16, 93, 2, 1, 0, 1'b0);
    hit = 1'b0;
    tick("v4_unstun", 16, 93, 2, 0, 0, 1'b0);
    tick("v4_caught", 16, 93, 2, 0, 1, 1'b0);
    hit = 1'b1; ChefX = 10'd300;
    tick("v4_hit_ignored", 16, 93, 2, 0, 1, 1'b0);
    hit = 1'b0; ChefY = 10'd400;
    tick("v4_still_caught", 16, 93, 2, 0, 1, 1'b0);

    // V6: reset out of CAUGHT, full spawn count with hit ignored
    Reset = 1'b1; ChefX = 10'd400; ChefY = 10'd96;
    tick("v6_rst_caught", 320, 96, 0, 0, 0, 1'b0);
    Reset = 1'b0; hit = 1'b1;
    for (int k = 1; k <= 60; k++) tick($sformatf("v6a_spawn%0d", k), 320, 96, 0, 0, 0, 1'b0);
    hit = 1'b0;
    tick("v6a_move", 321, 96, 0, 0, 0, 1'b0);
    hit = 1'b1;
    tick("v6_stun", 321, 96, 0, 1, 0, 1'b0);
    Reset = 1'b1;
    tick("v6_rst_stunned", 320, 96, 0, 0, 0, 1'b0);
    Reset = 1'b0; hit = 1'b0;
    for (int k = 1; k <= 60; k++) tick($sformatf("v6b_spawn%0d", k), 320, 96, 0, 0, 0, 1'b0);
    tick("v6b_move", 321, 96, 0, 0, 0, 1'b0);

    // V2: STEP=5 downward chase, final partial step, then catch at zero radius
    rst2 = 1'b1;
    tick("v2_reset", 320, 96, 0, 0, 0, 1'b1);
    rst2 = 1'b0;
    for (int k = 1; k <= 60; k++) tick($sformatf("v2_spawn%0d", k), 320, 96, 0, 0, 0, 1'b1);
    for (int k = 1; k <= 40; k++) tick($sformatf("v2_down%0d", k), 320, 96 + 5 * k, 3, 0, 0, 1'b1);
    tick("v2_partial", 320, 300, 3, 0, 0, 1'b1);
    tick("v2_caught", 320, 300, 3, 0, 1, 1'b1);
    tick("v2_hold", 320, 300, 3, 0, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_chase.md
ENEMY_CHASE -- requirements
Module: enemy_chase

Interface
REQ-001 The block SHALL declare these parameters (name, default, meaning):
- START_X, 10'd320, spawn X coordinate
- START_Y, 10'd96, spawn Y coordinate
- STEP, 10'd1, pixels moved per chase frame
- MIN_X / MAX_X, 10'd16 / 10'd623, horizontal clamp bounds
- MIN_Y / MAX_Y, 10'd16 / 10'd463, vertical clamp bounds
- SPAWN_FRAMES, 10'd60, frames held in SPAWN before chasing
- CATCH_R, 10'd8, catch radius per axis
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- frame_clk, input, 1, sole clock, one edge per video frame
- Reset, input, 1, synchronous active-high reset
- hit, input, 1, stun level from pepper stage (sausage_hit or egg_hit)
- ChefX, ChefY, input, 10 each, chef position
- EnemyX, EnemyY, output, 10 each, enemy position
- enemy_dir, output, 2, last move direction: 0 right, 1 left, 2 up, 3 down
- stunned, output, 1, high while in STUNNED
- chef_caught, output, 1, high while in CAUGHT
REQ-003 The block SHALL use one clock (frame_clk) and a synchronous, active-high reset (Reset), with all state updated only on the rising edge of frame_clk.

Function
REQ-004 The FSM SHALL have exactly four states: SPAWN, CHASE, STUNNED, CAUGHT.
REQ-005 In SPAWN, a 10-bit frame counter SHALL increment each frame; when it equals SPAWN_FRAMES-1, the next state SHALL be CHASE and the counter SHALL clear. Position SHALL hold at START_X/START_Y, and hit SHALL be ignored.
REQ-006 In CHASE, with dx=|ChefX-EnemyX| and dy=|ChefY-EnemyY| computed unsigned on 10 bits without wrap, the enemy SHALL move horizontally toward the chef if dx>=dy and dx!=0, else vertically if dy!=0, else hold.
REQ-007 The move distance SHALL be min(STEP, distance on the chosen axis), so the enemy never overshoots the chef coordinate.
REQ-008 The resulting coordinate SHALL be clamped to [MIN_X,MAX_X] or [MIN_Y,MAX_Y].
REQ-009 enemy_dir SHALL update to the direction of any nonzero move and hold otherwise.
REQ-010 Catch: in CHASE, if dx<=CATCH_R and dy<=CATCH_R, computed on the pre-move position, the next state SHALL be CAUGHT and no move SHALL occur that frame.
REQ-011 Stun: in CHASE, hit==1 SHALL cause the next state to be STUNNED with position held. Stun SHALL take priority over catch in the same frame.
REQ-012 In STUNNED, position and enemy_dir SHALL hold. When hit==0, the next state SHALL be CHASE, and movement SHALL resume on the following frame.
REQ-013 CAUGHT SHALL be terminal until Reset; position SHALL freeze, and hit and chef inputs SHALL be ignored.
REQ-014 stunned and chef_caught SHALL be registered, and SHALL be valid in the same cycle the state register holds STUNNED or CAUGHT respectively.
REQ-015 EnemyX/EnemyY SHALL be registered outputs, changing only on frame_clk edges.

Reset
REQ-016 When Reset==1 at a clock edge, the block SHALL set state=SPAWN, counter=0, EnemyX=START_X, EnemyY=START_Y, enemy_dir=0, stunned=0, chef_caught=0, regardless of current state, including mid-stun or CAUGHT.
REQ-017 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- V1 Spawn timing: Reset, then ChefX=400, ChefY=96 -> EnemyX stays 320 for 60 edges, then increments by 1 per frame with enemy_dir=0.
- V2 Axis choice and no overshoot: in CHASE with Enemy=(320,96), Chef=(320,300), STEP=5 -> EnemyY steps 101,106,... and stops exactly at Chef Y (or enters CAUGHT at dy<=8), enemy_dir=3.
- V3 Stun and resume: in CHASE with hit=1 for 100 frames -> stunned=1 and position frozen for all 100 frames; after hit falls, stunned=0 next edge and the position changes one frame later.
- V4 Catch, and stun beating catch: Chef within 8 px on both axes with hit=0 -> chef_caught=1 latched, and later hit pulses have no effect. The same geometry with hit=1 -> STUNNED, chef_caught=0.
- V5 Clamp: Chef=(0,96), Enemy near MIN_X -> EnemyX never drops below 16.
- V6 Reset mid-operation: Reset asserted during STUNNED and during CAUGHT -> next edge outputs are (320,96,0,0,0) and SPAWN restarts its full 60-frame count.
